// File: rtl/enemy_wave_ctrl_pkg.sv
// ============================================================================
// enemy_wave_ctrl_pkg : shared game geometry and enemy slot-state encoding
// Revision: 1.0
// ============================================================================
`default_nettype none

package enemy_wave_ctrl_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int SPRITE_W = 50;
  localparam int Y_LIMIT  = 430;
  localparam int COORD_W  = 10;
  localparam int LFSR_W   = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_EXPLODE = 2'd2
  } slot_state_t;

  // Single compare-subtract; input range 0..1023 lands inside 0..span-1 for span >= 512.
  function automatic logic [COORD_W-1:0] spawn_x_reduce(
    input logic [COORD_W-1:0] value,
    input logic [COORD_W-1:0] span
  );
    return (value >= span) ? (value - span) : value;
  endfunction

endpackage

`default_nettype wire

// File: rtl/enemy_wave_ctrl_lfsr10.sv
// ============================================================================
// lfsr10 : free-running 10-bit Fibonacci LFSR, polynomial x^10 + x^7 + 1
// Revision: 1.0
// ============================================================================
`default_nettype none

module lfsr10
  import enemy_wave_ctrl_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 10'h2A5
) (
  input  logic              clk,
  input  logic              rst,
  output logic [LFSR_W-1:0] lfsr_o
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  // Taps at bits 10 and 7 (1-based) give the maximal 1023-state sequence.
  assign lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[9] ^ lfsr_q[6]};

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

`default_nettype wire

// File: rtl/enemy_wave_ctrl.sv
// ============================================================================
// enemy_wave_ctrl : enemy slot pool scheduler (spawn, move, escape, explode)
// Revision: 1.0
// ============================================================================
`default_nettype none

module enemy_wave_ctrl #(
  parameter int          N_SLOTS       = 4,
  parameter int          SCREEN_W      = enemy_wave_ctrl_pkg::SCREEN_W,
  parameter int          SPRITE_W      = enemy_wave_ctrl_pkg::SPRITE_W,
  parameter int          Y_LIMIT       = enemy_wave_ctrl_pkg::Y_LIMIT,
  parameter int          SPAWN_TICKS   = 120,
  parameter int          EXPLODE_TICKS = 16,
  parameter logic [9:0]  LFSR_SEED     = 10'h2A5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       move_tick,
  input  logic                       enable,
  input  logic                       hit_valid,
  input  logic [$clog2(N_SLOTS)-1:0] hit_slot,
  output logic [N_SLOTS*10-1:0]      enemy_x,
  output logic [N_SLOTS*10-1:0]      enemy_y,
  output logic [N_SLOTS-1:0]         slot_active,
  output logic [N_SLOTS-1:0]         slot_exploding,
  output logic                       kill_pulse,
  output logic                       escape_pulse,
  output logic [15:0]                kill_count
);

  import enemy_wave_ctrl_pkg::*;

  localparam int SLOT_W  = $clog2(N_SLOTS);
  localparam int SPAWN_W = (SPAWN_TICKS > 1) ? $clog2(SPAWN_TICKS) : 1;
  localparam int EXPL_W  = (EXPLODE_TICKS > 1) ? $clog2(EXPLODE_TICKS) : 1;

  localparam logic [COORD_W-1:0] X_SPAN     = COORD_W'(SCREEN_W - SPRITE_W);
  localparam logic [COORD_W-1:0] Y_LAST     = COORD_W'(Y_LIMIT);
  localparam logic [SPAWN_W-1:0] SPAWN_TERM = SPAWN_W'(SPAWN_TICKS - 1);
  localparam logic [EXPL_W-1:0]  EXPL_TERM  = EXPL_W'(EXPLODE_TICKS - 1);

  logic                 tick_en;
  logic [LFSR_W-1:0]    lfsr_val;
  logic [COORD_W-1:0]   spawn_x;
  logic                 hit_ok;
  logic [N_SLOTS-1:0]   idle_vec;
  logic [N_SLOTS-1:0]   spawn_grant;
  logic [N_SLOTS-1:0]   kill_vec;
  logic [N_SLOTS-1:0]   esc_vec;
  logic                 any_idle;
  logic                 spawn_at_term;
  logic                 spawn_fire;

  logic [SPAWN_W-1:0]   spawn_cnt_q;
  logic [SPAWN_W-1:0]   spawn_cnt_d;
  logic [15:0]          kill_count_q;
  logic [15:0]          kill_count_d;
  logic                 kill_pulse_q;
  logic                 escape_pulse_q;

  lfsr10 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .lfsr_o (lfsr_val)
  );

  assign tick_en = move_tick && enable;
  assign spawn_x = spawn_x_reduce(lfsr_val, X_SPAN);
  assign hit_ok  = hit_valid && ({1'b0, hit_slot} < (SLOT_W + 1)'(N_SLOTS));

  // Lowest-index free slot wins; evaluated on pre-edge state so an escaping slot is never eligible.
  always_comb begin
    logic taken;
    spawn_grant = '0;
    taken       = 1'b0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (idle_vec[i] && !taken) begin
        spawn_grant[i] = 1'b1;
        taken          = 1'b1;
      end
    end
  end

  assign any_idle      = |idle_vec;
  assign spawn_at_term = (spawn_cnt_q == SPAWN_TERM);
  assign spawn_fire    = tick_en && spawn_at_term && any_idle;

  always_comb begin
    spawn_cnt_d = spawn_cnt_q;
    if (tick_en) begin
      if (spawn_at_term) begin
        if (any_idle) begin
          spawn_cnt_d = '0;
        end
      end else begin
        spawn_cnt_d = spawn_cnt_q + SPAWN_W'(1);
      end
    end
  end

  generate
    for (genvar i = 0; i < N_SLOTS; i++) begin : g_slot
      slot_state_t          state_q;
      slot_state_t          state_d;
      logic [COORD_W-1:0]   x_q;
      logic [COORD_W-1:0]   x_d;
      logic [COORD_W-1:0]   y_q;
      logic [COORD_W-1:0]   y_d;
      logic [EXPL_W-1:0]    ecnt_q;
      logic [EXPL_W-1:0]    ecnt_d;
      logic                 hit_me;
      logic                 kill_s;
      logic                 esc_s;

      assign hit_me = hit_ok && (hit_slot == SLOT_W'(i));

      always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        ecnt_d  = ecnt_q;
        kill_s  = 1'b0;
        esc_s   = 1'b0;
        case (state_q)
          ST_IDLE: begin
            if (spawn_fire && spawn_grant[i]) begin
              state_d = ST_ACTIVE;
              x_d     = spawn_x;
              y_d     = '0;
              ecnt_d  = '0;
            end
          end
          ST_ACTIVE: begin
            // A hit takes priority over an escape on the same tick.
            if (hit_me) begin
              state_d = ST_EXPLODE;
              ecnt_d  = '0;
              kill_s  = 1'b1;
            end else if (tick_en) begin
              if (y_q == Y_LAST) begin
                state_d = ST_IDLE;
                esc_s   = 1'b1;
              end else begin
                y_d = y_q + COORD_W'(1);
              end
            end
          end
          ST_EXPLODE: begin
            if (tick_en) begin
              if (ecnt_q == EXPL_TERM) begin
                state_d = ST_IDLE;
                ecnt_d  = '0;
              end else begin
                ecnt_d = ecnt_q + EXPL_W'(1);
              end
            end
          end
          default: begin
            state_d = ST_IDLE;
          end
        endcase
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          state_q <= ST_IDLE;
          x_q     <= '0;
          y_q     <= '0;
          ecnt_q  <= '0;
        end else begin
          state_q <= state_d;
          x_q     <= x_d;
          y_q     <= y_d;
          ecnt_q  <= ecnt_d;
        end
      end

      assign idle_vec[i]              = (state_q == ST_IDLE);
      assign slot_active[i]           = (state_q == ST_ACTIVE);
      assign slot_exploding[i]        = (state_q == ST_EXPLODE);
      assign enemy_x[10*i +: COORD_W] = x_q;
      assign enemy_y[10*i +: COORD_W] = y_q;
      assign kill_vec[i]              = kill_s;
      assign esc_vec[i]               = esc_s;
    end
  endgenerate

  // At most one slot can be hit per cycle, so the count steps by at most one.
  assign kill_count_d = (|kill_vec && (kill_count_q != 16'hFFFF)) ?
                        (kill_count_q + 16'd1) : kill_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      spawn_cnt_q    <= '0;
      kill_count_q   <= '0;
      kill_pulse_q   <= 1'b0;
      escape_pulse_q <= 1'b0;
    end else begin
      spawn_cnt_q    <= spawn_cnt_d;
      kill_count_q   <= kill_count_d;
      kill_pulse_q   <= |kill_vec;
      escape_pulse_q <= |esc_vec;
    end
  end

  assign kill_pulse   = kill_pulse_q;
  assign escape_pulse = escape_pulse_q;
  assign kill_count   = kill_count_q;

endmodule

`default_nettype wire

// File: tb/tb_enemy_wave_ctrl.sv
// ============================================================================
// tb_enemy_wave_ctrl : directed self-checking bench for enemy_wave_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_enemy_wave_ctrl;

  localparam int         N_SLOTS  = 4;
  localparam logic [9:0] SEED     = 10'h2A5;

  logic                 clk;
  logic                 rst;
  logic                 move_tick;
  logic                 enable;
  logic                 hit_valid;
  logic [1:0]           hit_slot;
  logic [N_SLOTS*10-1:0] enemy_x;
  logic [N_SLOTS*10-1:0] enemy_y;
  logic [N_SLOTS-1:0]   slot_active;
  logic [N_SLOTS-1:0]   slot_exploding;
  logic                 kill_pulse;
  logic                 escape_pulse;
  logic [15:0]          kill_count;

  int         n_checks;
  int         n_fail;
  logic [9:0] m_lfsr;
  logic [9:0] cap_lfsr;
  logic [9:0] sx;
  logic       esc_seen;

  enemy_wave_ctrl #(
    .N_SLOTS       (N_SLOTS),
    .SCREEN_W      (640),
    .SPRITE_W      (50),
    .Y_LIMIT       (430),
    .SPAWN_TICKS   (4),
    .EXPLODE_TICKS (16),
    .LFSR_SEED     (SEED)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .move_tick      (move_tick),
    .enable         (enable),
    .hit_valid      (hit_valid),
    .hit_slot       (hit_slot),
    .enemy_x        (enemy_x),
    .enemy_y        (enemy_y),
    .slot_active    (slot_active),
    .slot_exploding (slot_exploding),
    .kill_pulse     (kill_pulse),
    .escape_pulse   (escape_pulse),
    .kill_count     (kill_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR for x^10 + x^7 + 1, reset alongside the DUT.
  always @(posedge clk) begin
    if (rst) m_lfsr <= SEED;
    else     m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
  end

  function automatic logic [9:0] ref_x(input logic [9:0] v);
    return (v >= 10'd590) ? (v - 10'd590) : v;
  endfunction

  function automatic logic [31:0] slot_x(input int s);
    return 32'(enemy_x[s*10 +: 10]);
  endfunction

  function automatic logic [31:0] slot_y(input int s);
    return 32'(enemy_y[s*10 +: 10]);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge with outputs updated.
  task automatic do_tick();
    cap_lfsr  = m_lfsr;
    move_tick = 1'b1;
    @(negedge clk);
    move_tick = 1'b0;
  endtask

  task automatic do_hit(input int s);
    hit_valid = 1'b1;
    hit_slot  = 2'(s);
    @(negedge clk);
    hit_valid = 1'b0;
  endtask

  task automatic check_reset_state(input string pfx);
    check_eq({pfx, "_x"},       32'(enemy_x), 32'd0);
    check_eq({pfx, "_y"},       32'(enemy_y), 32'd0);
    check_eq({pfx, "_active"},  32'(slot_active), 32'd0);
    check_eq({pfx, "_explode"}, 32'(slot_exploding), 32'd0);
    check_eq({pfx, "_kpulse"},  32'(kill_pulse), 32'd0);
    check_eq({pfx, "_epulse"},  32'(escape_pulse), 32'd0);
    check_eq({pfx, "_kcount"},  32'(kill_count), 32'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    move_tick = 1'b0;
    enable    = 1'b0;
    hit_valid = 1'b0;
    hit_slot  = 2'd0;
    esc_seen  = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");

    rst    = 1'b0;
    enable = 1'b1;
    repeat (3) do_tick();
    check_eq("no_spawn_before_4th_tick", 32'(slot_active), 32'h0);
    do_tick();
    sx = ref_x(cap_lfsr);
    check_eq("first_spawn_active", 32'(slot_active), 32'h1);
    check_eq("first_spawn_y0", slot_y(0), 32'd0);
    check_eq("first_spawn_x0", slot_x(0), 32'(sx));
    check_eq("first_spawn_x0_range", 32'(slot_x(0) < 32'd590), 32'd1);

    // Ticks 5..16 spawn slots 1..3 every fourth tick.
    repeat (12) do_tick();
    check_eq("fill_active", 32'(slot_active), 32'hF);
    check_eq("fill_y0", slot_y(0), 32'd12);
    check_eq("fill_y1", slot_y(1), 32'd8);
    check_eq("fill_y2", slot_y(2), 32'd4);
    check_eq("fill_y3", slot_y(3), 32'd0);

    repeat (4) do_tick();
    check_eq("full_no_spawn_active", 32'(slot_active), 32'hF);
    check_eq("full_y0", slot_y(0), 32'd16);

    do_hit(2);
    check_eq("hit2_kpulse", 32'(kill_pulse), 32'd1);
    check_eq("hit2_explode", 32'(slot_exploding), 32'h4);
    check_eq("hit2_active", 32'(slot_active), 32'hB);
    check_eq("hit2_kcount", 32'(kill_count), 32'd1);
    check_eq("hit2_y_frozen", slot_y(2), 32'd8);
    @(negedge clk);
    check_eq("kpulse_one_cycle", 32'(kill_pulse), 32'd0);

    do_hit(2);
    check_eq("hit_exploding_kpulse", 32'(kill_pulse), 32'd0);
    check_eq("hit_exploding_kcount", 32'(kill_count), 32'd1);

    repeat (15) do_tick();
    check_eq("explode_15_ticks", 32'(slot_exploding), 32'h4);
    do_tick();
    check_eq("explode_done", 32'(slot_exploding), 32'h0);
    check_eq("explode_done_active", 32'(slot_active), 32'hB);
    check_eq("explode_done_y0", slot_y(0), 32'd32);
    do_tick();
    sx = ref_x(cap_lfsr);
    check_eq("respawn2_active", 32'(slot_active), 32'hF);
    check_eq("respawn2_y", slot_y(2), 32'd0);
    check_eq("respawn2_x", slot_x(2), 32'(sx));

    // Slot 0 sits at y=33; 397 ticks bring it to the last legal row.
    for (int k = 0; k < 397; k++) begin
      do_tick();
      esc_seen = esc_seen | escape_pulse;
    end
    check_eq("no_early_escape", 32'(esc_seen), 32'd0);
    check_eq("y0_at_limit", slot_y(0), 32'd430);
    check_eq("y1_before_escape", slot_y(1), 32'd426);
    check_eq("active_before_escape", 32'(slot_active), 32'hF);

    do_tick();
    check_eq("escape_pulse", 32'(escape_pulse), 32'd1);
    check_eq("escape_active", 32'(slot_active), 32'hE);
    check_eq("escape_y_held", slot_y(0), 32'd430);
    check_eq("escape_kcount", 32'(kill_count), 32'd1);
    @(negedge clk);
    check_eq("epulse_one_cycle", 32'(escape_pulse), 32'd0);

    do_hit(0);
    check_eq("hit_idle_kpulse", 32'(kill_pulse), 32'd0);
    check_eq("hit_idle_kcount", 32'(kill_count), 32'd1);
    check_eq("hit_idle_explode", 32'(slot_exploding), 32'h0);

    repeat (3) do_tick();
    check_eq("respawn0_active", 32'(slot_active), 32'hF);
    check_eq("y1_at_limit", slot_y(1), 32'd430);

    hit_valid = 1'b1;
    hit_slot  = 2'd1;
    do_tick();
    hit_valid = 1'b0;
    check_eq("hit_vs_escape_explode", 32'(slot_exploding), 32'h2);
    check_eq("hit_vs_escape_active", 32'(slot_active), 32'hD);
    check_eq("hit_vs_escape_kpulse", 32'(kill_pulse), 32'd1);
    check_eq("hit_vs_escape_epulse", 32'(escape_pulse), 32'd0);
    check_eq("hit_vs_escape_kcount", 32'(kill_count), 32'd2);
    check_eq("hit_vs_escape_y1", slot_y(1), 32'd430);

    enable = 1'b0;
    repeat (10) do_tick();
    check_eq("disabled_y0", slot_y(0), 32'd3);
    check_eq("disabled_y3", slot_y(3), 32'd423);
    check_eq("disabled_explode_held", 32'(slot_exploding), 32'h2);
    do_hit(3);
    check_eq("disabled_hit_explode", 32'(slot_exploding), 32'hA);
    check_eq("disabled_hit_kpulse", 32'(kill_pulse), 32'd1);
    check_eq("disabled_hit_kcount", 32'(kill_count), 32'd3);

    enable = 1'b1;
    rst    = 1'b1;
    @(negedge clk);
    check_reset_state("midrun_reset");
    rst = 1'b0;
    do_tick();
    check_eq("no_spawn_after_reset", 32'(slot_active), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/enemy_wave_ctrl.md
# enemy_wave_ctrl

Scheduler for the on-screen enemy pool. Owns up to `N_SLOTS` enemy slots: decides when and where each enemy spawns, advances every live enemy one row per movement tick, retires enemies that reach the bottom, and sequences a fixed-length explosion after a collision hit. Sits between the game-tick generator and the per-enemy sprite/render units, which consume its slot position and status outputs.

## Interface
Parameters:
- `N_SLOTS`, 4, number of enemy slots; must be ≥ 2.
- `SCREEN_W`, 640, horizontal resolution in pixels.
- `SPRITE_W`, 50, enemy sprite width and height.
- `Y_LIMIT`, 430, last legal top-row y; an enemy at this y escapes on the next move tick.
- `SPAWN_TICKS`, 120, move ticks between spawn attempts.
- `EXPLODE_TICKS`, 16, move ticks an explosion is displayed.
- `LFSR_SEED`, 10'h2A5, LFSR reset value; must be non-zero.

Ports:
- `clk` input 1: system clock. One clock domain only.
- `rst` input 1: reset, synchronous, active-high.
- `move_tick` input 1: one-`clk` pulse, game movement rate.
- `enable` input 1: when low, spawning and movement freeze. Hits are still processed.
- `hit_valid` input 1: collision report, one-cycle pulse.
- `hit_slot` input `$clog2(N_SLOTS)`: slot index for `hit_valid`.
- `enemy_x` output `N_SLOTS*10`: packed x of each slot; slot i is at `[10*i+9:10*i]`.
- `enemy_y` output `N_SLOTS*10`: packed y, same packing as `enemy_x`.
- `slot_active` output `N_SLOTS`: slot is flying.
- `slot_exploding` output `N_SLOTS`: slot is showing its explosion.
- `kill_pulse` output 1: one-cycle pulse when a hit is accepted.
- `escape_pulse` output 1: one-cycle pulse when one or more enemies escape on a tick.
- `kill_count` output 16: count of accepted hits; saturates at 16'hFFFF.

## Operation
- Each slot runs a three-state FSM: IDLE → ACTIVE → EXPLODE → IDLE. A slot can also go ACTIVE → IDLE directly by escaping.
- LFSR: 10 bits, polynomial x^10+x^7+1, advances every `clk` cycle regardless of `enable`.
- Spawn x = LFSR value reduced modulo `SCREEN_W-SPRITE_W` (590). Reduction is a single compare-subtract: if value ≥ 590, subtract 590. Result range is 0..589. Spawn y = 0.
- Spawn counter:
  - Increments on each enabled `move_tick`.
  - When it reaches `SPAWN_TICKS-1`, the lowest-index IDLE slot becomes ACTIVE and the counter clears.
  - If no slot is IDLE, the counter holds at terminal and retries on every subsequent enabled tick.
- ACTIVE slot, on each enabled `move_tick`:
  - If y == `Y_LIMIT`: slot goes to IDLE, x and y are unchanged, and `escape_pulse` fires.
  - Otherwise y increments by 1.
- Hit handling:
  - `hit_valid` on an ACTIVE `hit_slot` moves that slot to EXPLODE, freezes its x/y, fires `kill_pulse`, and increments `kill_count`.
  - A hit on an IDLE or EXPLODE slot is ignored: no pulse, no count.
  - An out-of-range `hit_slot` is ignored.
- EXPLODE: a per-slot counter counts enabled `move_tick`s. After `EXPLODE_TICKS` ticks the slot returns to IDLE.
- Simultaneous events, all in the same cycle:
  - Hit and escape on the same slot: the hit wins. Slot goes to EXPLODE, `kill_pulse` fires, `escape_pulse` does not.
  - Hit on a slot that is being spawned into: ignored, because the slot was IDLE before the edge.
  - Spawn and escape: the escaping slot is not eligible for the spawn. Eligibility is evaluated on pre-edge state.
- Reset mid-operation clears all slots on the next `clk` edge. No pending spawn survives reset.

## Timing
- All outputs are registered. State and position changes caused by a `move_tick` or `hit_valid` in cycle n are visible in cycle n+1.
- `kill_pulse` and `escape_pulse` are high for exactly cycle n+1.
- Reset values:
  - `enemy_x`, `enemy_y`: all 0.
  - `slot_active`, `slot_exploding`: 0.
  - `kill_pulse`, `escape_pulse`: 0.
  - `kill_count`: 0.
  - Spawn counter and explode counters: 0.
  - LFSR = `LFSR_SEED`.
- First spawn happens on the `SPAWN_TICKS`-th enabled move tick after reset.
- An enemy spawned at y=0 escapes on the (`Y_LIMIT`+1)-th tick after spawn.
- `move_tick` arriving while `enable` is low is dropped, not queued.

## Structure
- Shared game package holds: `SCREEN_W`, `SCREEN_H`, `SPRITE_W`, `Y_LIMIT`, and the slot-state enum `{ST_IDLE, ST_ACTIVE, ST_EXPLODE}`.
- One sub-module: `lfsr10`, with ports clk, rst, seed parameter, and a 10-bit value output.
- Slot logic is a generate loop inside this block.
- The free-slot priority encoder and spawn counter are local to this block.

## Test plan
- Reset, then `SPAWN_TICKS`=4 with 4 enabled ticks → slot 0 ACTIVE at y=0 with x<590. All other slots stay IDLE.
- Fill all 4 slots, then keep ticking → no spawn, and the counter holds. Hit slot 2, wait `EXPLODE_TICKS` ticks → slot 2 IDLE, then it respawns on the next tick.
- Drive an active slot to y=430, then one tick → `escape_pulse` for one cycle, slot IDLE, `kill_count` unchanged.
- `hit_valid` on slot 1 in the same cycle as its escape tick → slot 1 EXPLODE, `kill_pulse`=1, `escape_pulse`=0, `kill_count`+1.
- Hit an IDLE slot and an EXPLODE slot → no `kill_pulse`, `kill_count` unchanged. Preload `kill_count`=16'hFFFF, then a valid hit → stays FFFF.
- `enable`=0 for 10 ticks → y values frozen, but a hit still moves its slot to EXPLODE. Assert `rst` mid-run → every output matches its reset value on the next cycle.
